ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave.sv | 162 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: parametrised width/depth/wait states, byte-lane writes,
// write-to-read forwarding and a two-cycle ERROR response for illegal accesses.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | no data phase pending
//  ST_WAIT | wait counter running, HREADYOUT low
//  ST_DATA | data phase completes this cycle, OKAY
//  ST_ERR1 | first ERROR cycle, HREADYOUT low
//  ST_ERR2 | second ERROR cycle, HREADYOUT high
module ahb_sram_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HRESP
);

   localparam int NB  = DATA_W / 8;
   localparam int LNB = $clog2(NB);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   logic [2:0]        state, nxt_state;
   logic [2:0]        wcnt, nxt_wcnt;
   logic              a_write;
   logic [IW-1:0]     a_word;
   logic [NB-1:0]     a_strb;
   logic [DATA_W-1:0] hrdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] size_b, lane_off, word_idx;
   logic              size_err, align_err, range_err, legal;
   logic [NB-1:0]     strb;
   logic              accepting, take;
   logic [IW-1:0]     rd_word;
   logic              rd_go, fwd_hit;
   logic [DATA_W-1:0] rd_merged;
   logic              unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   // Address-phase decode: lane strobes and legality of the incoming transfer.
   always_comb begin
      size_b    = ADDR_W'(1) << HSIZE;
      lane_off  = HADDR & ADDR_W'(NB - 1);
      word_idx  = HADDR >> LNB;
      size_err  = (HSIZE > 3'(LNB));
      align_err = ((HADDR & (size_b - ADDR_W'(1))) != '0);
      range_err = (word_idx >= ADDR_W'(DEPTH));
      legal     = !(size_err || align_err || range_err);
      strb      = '0;
      for (int i = 0; i < NB; i++) begin
         strb[i] = (ADDR_W'(i) >= lane_off) && (ADDR_W'(i) < lane_off + size_b);
      end
   end

   // WAIT and ERR1 hold HREADY low on the bus, so no accept is taken there.
   assign accepting = (state != ST_WAIT) && (state != ST_ERR1);
   assign take      = HSEL && HTRANS[1] && HREADY && accepting;

   always_comb begin
      nxt_state = state;
      nxt_wcnt  = wcnt;
      case (state)
         ST_WAIT: begin
            if (wcnt == 3'd1) begin
               nxt_state = ST_DATA;
            end else begin
               nxt_wcnt = wcnt - 3'd1;
            end
         end
         ST_ERR1: nxt_state = ST_ERR2;
         default: begin
            if (take) begin
               if (!legal) begin
                  nxt_state = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  nxt_state = ST_WAIT;
                  nxt_wcnt  = 3'(WAIT_STATES);
               end else begin
                  nxt_state = ST_DATA;
               end
            end else begin
               nxt_state = ST_IDLE;
            end
         end
      endcase
   end

   // Read data is captured on the edge entering DATA; with zero wait states the
   // read word comes straight from the address phase and may coincide with a
   // write committing on the same edge, hence the merge.
   assign rd_word = (state == ST_WAIT) ? a_word : word_idx[IW-1:0];
   assign rd_go   = (nxt_state == ST_DATA) &&
                    ((state == ST_WAIT) ? !a_write : !HWRITE);
   assign fwd_hit = (state == ST_DATA) && a_write && (a_word == rd_word);

   always_comb begin
      rd_merged = mem[rd_word];
      for (int i = 0; i < NB; i++) begin
         if (fwd_hit && a_strb[i]) begin
            rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= ST_IDLE;
         wcnt     <= '0;
         a_write  <= 1'b0;
         a_word   <= '0;
         a_strb   <= '0;
         hrdata_q <= '0;
      end else begin
         state <= nxt_state;
         wcnt  <= nxt_wcnt;
         if (take) begin
            a_write <= HWRITE;
            a_word  <= word_idx[IW-1:0];
            a_strb  <= strb;
         end
         if (rd_go) begin
            hrdata_q <= rd_merged;
         end
      end
   end

   // Array contents survive reset; only the pending write is dropped.
   always_ff @(posedge HCLK) begin
      if (!HRESET && (state == ST_DATA) && a_write) begin
         for (int i = 0; i < NB; i++) begin
            if (a_strb[i]) begin
               mem[a_word][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
   assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
   assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) driven by a
// pipelined AHB master and checked against a byte-array memory model.
module tb_ahb_sram_slave;

   typedef struct {
      bit          kind_idle;
      logic        idle_sel;
      logic [1:0]  idle_trans;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_rd;
      logic [31:0] exp_mask;
   } op_t;

   logic        hclk = 1'b0;
   logic        hreset    [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hreadyout [2];
   logic [31:0] hrdata    [2];
   logic        hresp     [2];

   logic [7:0]  mdl   [2][4096];
   bit          known [2][4096];
   op_t         q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 hclk = ~hclk;

   ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
      .HCLK(hclk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
      .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
      .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
   );

   ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
      .HCLK(hclk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
      .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
      .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic string tg(input string s, input int k);
      return $sformatf("%s_dut%0d", s, k);
   endfunction

   function automatic op_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata);
      op_t op;
      op       = '{default: '0};
      op.wr    = wr;
      op.addr  = addr;
      op.size  = size;
      op.wdata = wdata;
      return op;
   endfunction

   // Applies a transfer to the model in issue order and fills in what the bus must show.
   function automatic op_t model_apply(input int k, input op_t op);
      longint unsigned a;
      int sz;
      int base;
      a  = op.addr;
      sz = 1 << op.size;
      op.exp_err  = (sz > 4) || ((a % sz) != 0) || ((a / 4) >= 1024);
      op.exp_rd   = '0;
      op.exp_mask = '0;
      if (!op.exp_err) begin
         if (op.wr) begin
            for (int b = 0; b < sz; b++) begin
               int ba = int'(a) + b;
               mdl[k][ba]   = op.wdata[8*(ba % 4) +: 8];
               known[k][ba] = 1'b1;
            end
         end else begin
            base = int'(a) - int'(a % 4);
            for (int l = 0; l < 4; l++) begin
               op.exp_rd[8*l +: 8] = mdl[k][base + l];
               if (known[k][base + l]) op.exp_mask[8*l +: 8] = 8'hff;
            end
         end
      end
      return op;
   endfunction

   function automatic op_t rand_op();
      op_t op;
      int  r;
      op = '{default: '0};
      r  = $urandom_range(0, 11);
      if (r == 0) begin
         op.kind_idle = 1'b1;
         case ($urandom_range(0, 3))
            0:       begin op.idle_sel = 1'b0; op.idle_trans = 2'b10; end
            1:       begin op.idle_sel = 1'b1; op.idle_trans = 2'b00; end
            2:       begin op.idle_sel = 1'b1; op.idle_trans = 2'b01; end
            default: begin op.idle_sel = 1'b0; op.idle_trans = 2'b11; end
         endcase
      end else begin
         op.wr    = 1'($urandom_range(0, 1));
         op.size  = 3'($urandom_range(0, 2));
         op.addr  = 32'($urandom_range(0, 63) * 4 + ($urandom_range(0, 3) & ~((1 << op.size) - 1)));
         op.wdata = $urandom;
         if (r == 1) begin
            case ($urandom_range(0, 2))
               0:       op.size = 3'($urandom_range(3, 7));
               1:       begin op.size = 3'($urandom_range(1, 2)); op.addr = op.addr | 32'h1; end
               default: op.addr = op.addr + 32'h1000 * $urandom_range(1, 4);
            endcase
         end
      end
      return op;
   endfunction

   task automatic drive_idle(input int k);
      hsel[k]   = 1'b0;
      htrans[k] = 2'b00;
      hwrite[k] = 1'b0;
      haddr[k]  = '0;
      hsize[k]  = '0;
   endtask

   // Pipelined master: each cycle completes the pending data phase (if ready)
   // and issues the next queued address phase.
   task automatic run_ops(input int k);
      op_t  d, a;
      bit   d_valid = 0;
      bit   prev_idle = 0;
      bit   ready;
      int   waits = 0;
      int   ws;
      logic resp_early = 1'b0;
      ws = (k == 0) ? 0 : 3;
      d  = '{default: '0};
      while (q.size() > 0 || d_valid) begin
         @(negedge hclk);
         ready = hreadyout[k];
         if (prev_idle) begin
            check_eq(tg("idle_ready", k), hreadyout[k], 1'b1);
            check_eq(tg("idle_resp", k), hresp[k], 1'b0);
         end
         prev_idle = 0;
         if (d_valid) begin
            hwdata[k] = d.wdata;
            if (!ready) begin
               waits++;
               resp_early |= hresp[k];
               if (waits > 12) begin
                  check_eq(tg("timeout_waits", k), waits, d.exp_err ? 1 : ws);
                  q.delete();
                  drive_idle(k);
                  return;
               end
            end else begin
               check_eq(tg("resp", k), hresp[k], d.exp_err);
               check_eq(tg("waits", k), waits, d.exp_err ? 1 : ws);
               if (waits > 0) check_eq(tg("wait_resp", k), resp_early, d.exp_err);
               if (!d.wr && !d.exp_err)
                  check_eq(tg($sformatf("rdata@%0h", d.addr), k),
                           hrdata[k] & d.exp_mask, d.exp_rd & d.exp_mask);
               d_valid = 0;
            end
         end
         if (ready && q.size() > 0) begin
            a = q.pop_front();
            if (a.kind_idle) begin
               hsel[k]   = a.idle_sel;
               htrans[k] = a.idle_trans;
               haddr[k]  = $urandom;
               hwrite[k] = 1'($urandom_range(0, 1));
               hsize[k]  = '0;
               prev_idle = 1;
            end else begin
               a          = model_apply(k, a);
               hsel[k]    = 1'b1;
               htrans[k]  = 2'b10 | 2'($urandom_range(0, 1));
               haddr[k]   = a.addr;
               hwrite[k]  = a.wr;
               hsize[k]   = a.size;
               d          = a;
               d_valid    = 1;
               waits      = 0;
               resp_early = 1'b0;
            end
         end else begin
            drive_idle(k);
         end
      end
      drive_idle(k);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         hreset[k] = 1'b1;
         hwdata[k] = '0;
         drive_idle(k);
      end
      repeat (3) @(negedge hclk);
      for (int k = 0; k < 2; k++) begin
         check_eq(tg("rst_ready", k), hreadyout[k], 1'b1);
         check_eq(tg("rst_resp", k), hresp[k], 1'b0);
         check_eq(tg("rst_rdata", k), hrdata[k], 32'h0);
         hreset[k] = 1'b0;
      end

      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 64; w++) q.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom));
         q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
         q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
         q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h11223344));
         q.push_back(mk(1'b1, 32'h22, 3'd0, 32'h00AA0000));
         q.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
         q.push_back(mk(1'b1, 32'h40, 3'd2, 32'h55667788));
         q.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
         q.push_back(mk(1'b1, 32'h1000, 3'd2, 32'hCAFEF00D));
         q.push_back(mk(1'b1, 32'h2, 3'd2, 32'hCAFEF00D));
         q.push_back(mk(1'b1, 32'h8, 3'd3, 32'hCAFEF00D));
         q.push_back(mk(1'b0, 32'h1000, 3'd2, 32'h0));
         q.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
         q.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0));
         run_ops(k);
      end

      // Reset during the second wait cycle of a write on the wait-state instance.
      @(negedge hclk);
      check_eq("rstw_pre_ready_dut1", hreadyout[1], 1'b1);
      hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h30; hsize[1] = 3'd2;
      @(negedge hclk);
      drive_idle(1);
      hwdata[1] = 32'hBADC0FFE;
      check_eq("rstw_wait1_dut1", hreadyout[1], 1'b0);
      @(negedge hclk);
      check_eq("rstw_wait2_dut1", hreadyout[1], 1'b0);
      hreset[1] = 1'b1;
      @(negedge hclk);
      hreset[1] = 1'b0;
      check_eq("rstw_ready_dut1", hreadyout[1], 1'b1);
      check_eq("rstw_resp_dut1", hresp[1], 1'b0);
      check_eq("rstw_rdata_dut1", hrdata[1], 32'h0);
      q.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0));
      run_ops(1);

      // Reset during the first error cycle on the zero-wait instance.
      @(negedge hclk);
      hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h8; hsize[0] = 3'd3;
      @(negedge hclk);
      drive_idle(0);
      check_eq("rste_err1_ready_dut0", hreadyout[0], 1'b0);
      check_eq("rste_err1_resp_dut0", hresp[0], 1'b1);
      hreset[0] = 1'b1;
      @(negedge hclk);
      hreset[0] = 1'b0;
      check_eq("rste_ready_dut0", hreadyout[0], 1'b1);
      check_eq("rste_resp_dut0", hresp[0], 1'b0);
      q.push_back(mk(1'b0, 32'h8, 3'd2, 32'h0));
      run_ops(0);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 250; i++) q.push_back(rand_op());
         q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
         run_ops(k);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
